mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  E-stage instruction valid; low means alu_class is ignored (stall/flush bubble).
REQ-006 alu_class  input  4  decoded class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-007 src_a  input  32  rs operand (dividend / multiplicand / mthi-mtlo data).
REQ-008 src_b  input  32  rt operand (divisor / multiplier).
REQ-009 start  output  1  combinational; high when a class 1-4 request is accepted this cycle.
REQ-010 busy  output  1  registered; high while an accepted operation is in flight.
REQ-011 md_stall  output  1  combinational; req_valid && class in 1..8 && (start_blocked || busy), for the hazard unit.
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.
REQ-014 rd_data  output  32  combinational: hi when class 5, lo when class 6, else 0.

Function
REQ-015 FSM states IDLE and BUSY; reset state IDLE.
REQ-016 Accept: in IDLE with req_valid and class 1-4, start=1; operands computed and latched into pend_hi/pend_lo; counter loaded with MULT_CYCLES or DIV_CYCLES; next state BUSY.
REQ-017 BUSY: busy=1, counter decrements each cycle; on the cycle counter==1, HI<=pend_hi, LO<=pend_lo, next state IDLE, busy drops next cycle.
REQ-018 Latency: start in cycle T, busy high cycles T+1..T+N, HI/LO visible from cycle T+N+1 (N = configured cycles).
REQ-019 mult: {HI,LO} = signed 32x32 -> 64 product; multu unsigned.
REQ-020 div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign; divu unsigned.
REQ-021 div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-022 Divisor zero (div or divu): operation runs full DIV_CYCLES; HI and LO left unchanged.
REQ-023 mthi/mtlo in IDLE with req_valid: HI (resp. LO) <= src_a at next edge; no busy.
REQ-024 Any class 1-8 request while busy=1 is not executed and raises md_stall; mfhi/mflo during busy likewise stall (rd_data still shows current hi/lo).
REQ-025 start_blocked is 0; a request in the same cycle busy falls is already IDLE-visible only next cycle (no back-to-back in final busy cycle).
REQ-026 req_valid=0 or class 0/9-15: no state change.

Reset
REQ-027 Reset at any time, including mid-BUSY: state IDLE, counter 0, busy 0, HI 0, LO 0, pend_hi/pend_lo 0; in-flight result discarded.
REQ-028 Reset has priority over all requests in the same cycle.

Structure
REQ-029 Shared package holds alu_class encodings (MD_NONE..MD_MTLO) and default latency constants; the decoder uses the same package.
REQ-030 One sub-module md_arith: combinational 64-bit result from class, src_a, src_b, including div-by-zero flag.

Verification
REQ-031 mult 0xFFFFFFFF x 0x00000002 -> start 1 cycle, busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 multu 0xFFFFFFFF x 0x00000002 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
REQ-033 div -7 / 2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 after mthi 0x11, mtlo 0x22 -> HI=0x11, LO=0x22 unchanged.
REQ-034 mflo issued cycle after mult start -> md_stall=1 for 5 cycles, then rd_data=product LO, md_stall=0.
REQ-035 reset asserted 3 cycles into div -> busy=0, HI=LO=0 next cycle, no later write.
REQ-036 mthi 0xDEADBEEF with req_valid=0 -> HI unchanged; with req_valid=1 -> HI=0xDEADBEEF next cycle.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multiply/divide unit and the instruction decoder:
//   - md_class_e    : alu_class encodings (MD_NONE .. MD_MTLO); 9-15 are unused
//   - md_state_e    : FSM state encoding
//   - default latency constants for multiply and divide
//   - is_md_op()    : true for any class the unit acts on (1..8)
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_class_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Classes 1..8 touch HI/LO and therefore interact with the busy window.
  function automatic logic is_md_op(input logic [3:0] cls);
    return (cls >= 4'd1) && (cls <= 4'd8);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ----------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the E-stage pipeline (master) and the
// multiply/divide unit (slave).
//   req_valid, alu_class, src_a, src_b : request from the pipeline
//   start, busy, md_stall              : status back to pipeline / hazard unit
//   hi, lo, rd_data                    : architectural HI/LO and mfhi/mflo data
// ----------------------------------------------------------------------------
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic        req_valid;
  logic [3:0]  alu_class;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output req_valid, alu_class, src_a, src_b,
    input  start, busy, md_stall, hi, lo, rd_data
  );

  modport slave (
    input  req_valid, alu_class, src_a, src_b,
    output start, busy, md_stall, hi, lo, rd_data
  );

endinterface

// File: rtl/mult_div_unit_md_arith.sv
// ----------------------------------------------------------------------------
// md_arith
// Combinational arithmetic core of the multiply/divide unit.
//   alu_class   in  : operation class (only 1..4 produce a result)
//   src_a/src_b in  : dividend/multiplicand and divisor/multiplier
//   result      out : {hi, lo} of the operation (product, or {rem, quot})
//   div_by_zero out : div/divu with a zero divisor
// Signed division is done on magnitudes so that 0x80000000 / -1 yields
// 0x80000000 with remainder 0 without relying on signed overflow behaviour.
// ----------------------------------------------------------------------------
module md_arith
  import mult_div_unit_pkg::*;
(
  input  logic [3:0]  alu_class,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] a_sext_s;
  logic [63:0] b_sext_s;
  logic [63:0] a_zext_s;
  logic [63:0] b_zext_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic        b_zero_s;
  logic [31:0] s_divisor_s;
  logic [31:0] u_divisor_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] s_quot_s;
  logic [31:0] s_rem_s;

  // Operand conditioning and both divider flavours; a zero divisor is
  // replaced by 1 so the divide operators never see zero.
  always_comb begin
    a_sext_s    = {{32{src_a[31]}}, src_a};
    b_sext_s    = {{32{src_b[31]}}, src_b};
    a_zext_s    = {32'd0, src_a};
    b_zext_s    = {32'd0, src_b};
    a_mag_s     = src_a[31] ? (32'd0 - src_a) : src_a;
    b_mag_s     = src_b[31] ? (32'd0 - src_b) : src_b;
    b_zero_s    = (src_b == 32'd0);
    s_divisor_s = b_zero_s ? 32'd1 : b_mag_s;
    u_divisor_s = b_zero_s ? 32'd1 : src_b;
    q_mag_s     = a_mag_s / s_divisor_s;
    r_mag_s     = a_mag_s % s_divisor_s;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    s_quot_s    = (src_a[31] ^ src_b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    s_rem_s     = src_a[31] ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Result selection by operation class.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (alu_class)
      MD_MULT:  result = a_sext_s * b_sext_s;
      MD_MULTU: result = a_zext_s * b_zext_s;
      MD_DIV: begin
        result      = {s_rem_s, s_quot_s};
        div_by_zero = b_zero_s;
      end
      MD_DIVU: begin
        result      = {src_a % u_divisor_s, src_a / u_divisor_s};
        div_by_zero = b_zero_s;
      end
      default: result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle MIPS-style HI/LO unit. mult/multu/div/divu are accepted in IDLE,
// their result is computed immediately and parked in pend_hi/pend_lo, and it
// is committed to HI/LO after MULT_CYCLES or DIV_CYCLES busy cycles. mthi/mtlo
// write directly in IDLE. Any HI/LO class request while busy raises md_stall.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mult_div_unit_if.slave (request, status, HI/LO, rd_data)
// ----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 1) ? 1 : $clog2(MAX_CYCLES + 1);

  md_state_e          state_r;
  md_state_e          state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic [31:0]        pend_hi_r;
  logic [31:0]        pend_hi_nxt_s;
  logic [31:0]        pend_lo_r;
  logic [31:0]        pend_lo_nxt_s;
  logic               pend_dz_r;
  logic               pend_dz_nxt_s;
  logic [31:0]        hi_r;
  logic [31:0]        hi_nxt_s;
  logic [31:0]        lo_r;
  logic [31:0]        lo_nxt_s;
  logic               busy_r;
  logic               start_s;
  logic               start_blocked_s;
  logic [63:0]        arith_result_s;
  logic               arith_dz_s;
  logic [31:0]        rd_data_s;

  // No structural hazard other than busy can hold off a request.
  assign start_blocked_s = 1'b0;

  md_arith u_md_arith (
    .alu_class   (bus.alu_class),
    .src_a       (bus.src_a),
    .src_b       (bus.src_b),
    .result      (arith_result_s),
    .div_by_zero (arith_dz_s)
  );

  // State, counter, pending result and architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_dz_r <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
      pend_dz_r <= pend_dz_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      busy_r    <= (state_nxt_s == ST_BUSY);
    end
  end

  // Next-state, acceptance and HI/LO update logic.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    pend_dz_nxt_s = pend_dz_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    start_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          case (bus.alu_class)
            MD_MULT, MD_MULTU: begin
              start_s       = 1'b1;
              pend_hi_nxt_s = arith_result_s[63:32];
              pend_lo_nxt_s = arith_result_s[31:0];
              pend_dz_nxt_s = 1'b0;
              cnt_nxt_s     = CNT_W'(MULT_CYCLES);
              state_nxt_s   = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              start_s       = 1'b1;
              pend_hi_nxt_s = arith_result_s[63:32];
              pend_lo_nxt_s = arith_result_s[31:0];
              pend_dz_nxt_s = arith_dz_s;
              cnt_nxt_s     = CNT_W'(DIV_CYCLES);
              state_nxt_s   = ST_BUSY;
            end
            MD_MTHI: hi_nxt_s = bus.src_a;
            MD_MTLO: lo_nxt_s = bus.src_a;
            default: state_nxt_s = ST_IDLE;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        // "<= 1" also terminates a zero-latency configuration instead of
        // letting the counter wrap.
        if (cnt_r <= CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          // A zero divisor runs the full latency but leaves HI/LO alone.
          if (!pend_dz_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // mfhi/mflo read port; shows current HI/LO even while stalled.
  always_comb begin
    rd_data_s = 32'd0;
    case (bus.alu_class)
      MD_MFHI: rd_data_s = hi_r;
      MD_MFLO: rd_data_s = lo_r;
      default: rd_data_s = 32'd0;
    endcase
  end

  assign bus.start    = start_s;
  assign bus.busy     = busy_r;
  assign bus.md_stall = bus.req_valid && is_md_op(bus.alu_class) && (start_blocked_s || busy_r);
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.rd_data  = rd_data_s;

endmodule
